// File: rtl/mclk_ce_gen.sv
// Master-clock enable generator: qualifies PLL lock into a core reset and derives
// single-cycle CPU and sound clock enables from the PLL output clock.
module mclk_ce_gen #(
  parameter int unsigned M68K_DIV  = 7,
  parameter int unsigned Z80_DIV   = 15,
  parameter int unsigned FM_DIV    = 6,
  parameter int unsigned PSG_DIV   = 16,
  parameter int unsigned LOCK_WAIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic lock,
  input  logic run,
  input  logic resync,
  output logic sys_reset,
  output logic ce_m68k,
  output logic ce_z80,
  output logic ce_fm,
  output logic ce_psg
);

  localparam int unsigned LW_W   = $clog2(LOCK_WAIT + 1);
  localparam int unsigned M68K_W = (M68K_DIV > 1) ? $clog2(M68K_DIV) : 1;
  localparam int unsigned Z80_W  = (Z80_DIV  > 1) ? $clog2(Z80_DIV)  : 1;
  localparam int unsigned FM_W   = (FM_DIV   > 1) ? $clog2(FM_DIV)   : 1;
  localparam int unsigned PSG_W  = (PSG_DIV  > 1) ? $clog2(PSG_DIV)  : 1;

  localparam logic [LW_W-1:0]   LW_MAX    = LW_W'(LOCK_WAIT);
  localparam logic [M68K_W-1:0] M68K_LAST = M68K_W'(M68K_DIV - 1);
  localparam logic [Z80_W-1:0]  Z80_LAST  = Z80_W'(Z80_DIV - 1);
  localparam logic [FM_W-1:0]   FM_LAST   = FM_W'(FM_DIV - 1);
  localparam logic [PSG_W-1:0]  PSG_LAST  = PSG_W'(PSG_DIV - 1);

  if (M68K_DIV < 2) $error("M68K_DIV must be at least 2");
  if (Z80_DIV < 2)  $error("Z80_DIV must be at least 2");
  if (FM_DIV < 1)   $error("FM_DIV must be at least 1");
  if (PSG_DIV < 1)  $error("PSG_DIV must be at least 1");
  if (LOCK_WAIT < 1) $error("LOCK_WAIT must be at least 1");

  logic              r_lock_meta;
  logic              r_lock_s;
  logic [LW_W-1:0]   r_stable;
  logic [M68K_W-1:0] r_m68k_cnt;
  logic [Z80_W-1:0]  r_z80_cnt;
  logic [FM_W-1:0]   r_fm_cnt;
  logic [PSG_W-1:0]  r_psg_cnt;

  logic w_ready;
  logic w_active;
  logic w_m68k_tick;
  logic w_z80_tick;

  // ready is combinational so it drops in the very cycle the synchronized lock falls
  assign w_ready     = r_lock_s && (r_stable == LW_MAX);
  assign w_active    = w_ready && run && !resync;
  assign w_m68k_tick = w_active && (r_m68k_cnt == M68K_LAST);
  assign w_z80_tick  = w_active && (r_z80_cnt == Z80_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_stable    <= '0;
      sys_reset   <= 1'b1;
    end else begin
      r_lock_meta <= lock;
      r_lock_s    <= r_lock_meta;
      if (!r_lock_s)
        r_stable <= '0;
      else if (r_stable != LW_MAX)
        r_stable <= r_stable + 1'b1;
      sys_reset <= !w_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !w_ready || resync) begin
      r_m68k_cnt <= '0;
      r_z80_cnt  <= '0;
      r_fm_cnt   <= '0;
      r_psg_cnt  <= '0;
    end else if (run) begin
      r_m68k_cnt <= (r_m68k_cnt == M68K_LAST) ? '0 : r_m68k_cnt + 1'b1;
      r_z80_cnt  <= (r_z80_cnt == Z80_LAST) ? '0 : r_z80_cnt + 1'b1;
      if (w_m68k_tick)
        r_fm_cnt <= (r_fm_cnt == FM_LAST) ? '0 : r_fm_cnt + 1'b1;
      if (w_z80_tick)
        r_psg_cnt <= (r_psg_cnt == PSG_LAST) ? '0 : r_psg_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ce_m68k <= 1'b0;
      ce_z80  <= 1'b0;
      ce_fm   <= 1'b0;
      ce_psg  <= 1'b0;
    end else begin
      ce_m68k <= w_m68k_tick;
      ce_z80  <= w_z80_tick;
      ce_fm   <= w_m68k_tick && (r_fm_cnt == FM_LAST);
      ce_psg  <= w_z80_tick && (r_psg_cnt == PSG_LAST);
    end
  end

endmodule

// File: tb/tb_mclk_ce_gen.sv
// Directed bench for mclk_ce_gen with LOCK_WAIT=16: lock qualification, enable
// phasing/counts, run freeze, resync, lock loss and mid-run reset.
module tb_mclk_ce_gen;

  localparam int M68K_P = 7;
  localparam int Z80_P  = 15;

  logic clk = 1'b0;
  logic reset, lock, run, resync;
  logic sys_reset, ce_m68k, ce_z80, ce_fm, ce_psg;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  int f_m68k, f_z80, f_fm, f_psg, f_srlo;
  int n_m68k, n_z80, n_fm, n_psg;
  int last_m68k, last_z80, per_err;
  bit chk_period = 1'b0;
  int align_err = 0;
  int wide_err = 0;
  logic p_m68k = 1'b0, p_z80 = 1'b0, p_fm = 1'b0, p_psg = 1'b0;

  mclk_ce_gen #(.LOCK_WAIT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .lock      (lock),
    .run       (run),
    .resync    (resync),
    .sys_reset (sys_reset),
    .ce_m68k   (ce_m68k),
    .ce_z80    (ce_z80),
    .ce_fm     (ce_fm),
    .ce_psg    (ce_psg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    align_err <= align_err + int'(ce_fm && !ce_m68k) + int'(ce_psg && !ce_z80);
    wide_err  <= wide_err + int'(ce_m68k && p_m68k) + int'(ce_z80 && p_z80)
                          + int'(ce_fm && p_fm) + int'(ce_psg && p_psg);
    p_m68k <= ce_m68k;
    p_z80  <= ce_z80;
    p_fm   <= ce_fm;
    p_psg  <= ce_psg;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Advance to cycle 'target', collecting first-occurrence and count stats for the window.
  task automatic run_to(input int target);
    f_m68k = -1; f_z80 = -1; f_fm = -1; f_psg = -1; f_srlo = -1;
    n_m68k = 0; n_z80 = 0; n_fm = 0; n_psg = 0;
    last_m68k = -1; last_z80 = -1;
    while (cyc < target) begin
      step();
      if (ce_m68k) begin
        if (f_m68k < 0) f_m68k = cyc;
        if (chk_period && last_m68k >= 0 && cyc - last_m68k != M68K_P) per_err++;
        last_m68k = cyc;
        n_m68k++;
      end
      if (ce_z80) begin
        if (f_z80 < 0) f_z80 = cyc;
        if (chk_period && last_z80 >= 0 && cyc - last_z80 != Z80_P) per_err++;
        last_z80 = cyc;
        n_z80++;
      end
      if (ce_fm) begin
        if (f_fm < 0) f_fm = cyc;
        n_fm++;
      end
      if (ce_psg) begin
        if (f_psg < 0) f_psg = cyc;
        n_psg++;
      end
      if (!sys_reset && f_srlo < 0) f_srlo = cyc;
    end
  endtask

  function automatic int ce_vec();
    return int'({ce_m68k, ce_z80, ce_fm, ce_psg});
  endfunction

  initial begin
    per_err = 0;
    reset = 1'b1; lock = 1'b1; run = 1'b1; resync = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sys_reset", int'(sys_reset), 1);
    check("reset_ce", ce_vec(), 0);

    // cycle N is the interval after the N-th rising edge with reset low
    reset = 1'b0;
    cyc = 0;
    run_to(18);
    check("qual_no_release_by_18", f_srlo, -1);
    check("qual_no_ce", n_m68k + n_z80 + n_fm + n_psg, 0);

    chk_period = 1'b1;
    run_to(3378);
    chk_period = 1'b0;
    check("sys_reset_fall_edge", f_srlo, 19);
    check("first_m68k", f_m68k, 25);
    check("first_z80", f_z80, 33);
    check("first_fm", f_fm, 60);
    check("first_psg", f_psg, 258);
    check("count_m68k", n_m68k, 480);
    check("count_z80", n_z80, 224);
    check("count_fm", n_fm, 80);
    check("count_psg", n_psg, 14);
    check("period_errs", per_err, 0);

    // run low for 100 cycles starting where m68k_cnt is 3
    run_to(3381);
    run = 1'b0;
    run_to(3481);
    check("run_gap_no_ce", n_m68k + n_z80 + n_fm + n_psg, 0);
    run = 1'b1;
    run_to(3490);
    check("run_resume_m68k", f_m68k, 3485);

    // resync in a cycle that would otherwise tick m68k
    run_to(3491);
    resync = 1'b1;
    run_to(3492);
    resync = 1'b0;
    check("resync_ce_zero", ce_vec(), 0);
    run_to(3541);
    check("resync_m68k", f_m68k, 3499);
    check("resync_z80", f_z80, 3507);
    check("resync_fm", f_fm, 3534);

    // lock dropped for 5 cycles
    lock = 1'b0;
    run_to(3543);
    check("lockloss_sys_reset_t2", int'(sys_reset), 0);
    run_to(3544);
    check("lockloss_sys_reset_t3", int'(sys_reset), 1);
    check("lockloss_ce_zero", ce_vec(), 0);
    run_to(3546);
    lock = 1'b1;
    run_to(3581);
    check("relock_release", f_srlo, 3565);
    check("relock_m68k", f_m68k, 3571);
    check("relock_z80", f_z80, 3579);

    // reset in a cycle that would otherwise produce ce_m68k and ce_fm
    run_to(3605);
    reset = 1'b1;
    run_to(3606);
    check("midreset_sys_reset", int'(sys_reset), 1);
    check("midreset_ce", ce_vec(), 0);
    run_to(3607);
    reset = 1'b0;
    run_to(3640);
    check("rereset_release", f_srlo, 3626);
    check("rereset_m68k", f_m68k, 3632);

    check("align_errs", align_err, 0);
    check("wide_errs", wide_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
